// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package inst_fetch_pkg;

    // Width of one instruction word.
    localparam int INST_W     = 9;
    // Default instruction-address width (2**DEFAULT_IW-word program space).
    localparam int DEFAULT_IW = 8;

    // Fetch controller states.
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } fetch_state_t;

    // Source selection for the next program counter.
    typedef enum logic [1:0] {
        PC_INC,
        PC_ABS,
        PC_REL
    } pc_sel_t;

endpackage

// File: rtl/pc_next.sv
// Next-PC datapath: sequential increment, absolute target, or
// PC-relative target computed from the address of the branch itself.
module pc_next
    import inst_fetch_pkg::*;
#(
    parameter int IW = DEFAULT_IW
) (
    input  pc_sel_t       sel,
    input  logic [IW-1:0] pc,
    input  logic [IW-1:0] pc_out,
    input  logic [IW-1:0] target,
    output logic [IW-1:0] next_pc
);

    // Select and compute the candidate next PC; all sums wrap modulo 2**IW.
    always_comb begin
        // NOTE: assign a default before the case so no path leaves next_pc unassigned (no latch).
        next_pc = pc + IW'(1);
        unique case (sel)
            PC_ABS:  next_pc = target;
            // The offset is already IW bits wide, so sign extension to IW is the
            // identity and a plain IW-bit add yields the two's-complement result.
            PC_REL:  next_pc = pc_out + target;
            default: next_pc = pc + IW'(1);
        endcase
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: drives the ROM address from the PC, registers the
// returned instruction for decode, and handles stall, branch and halt.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int IW = DEFAULT_IW
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [IW-1:0]     StartAddr,
    input  logic              Stall,
    input  logic              BranchEn,
    input  logic              BranchRel,
    input  logic [IW-1:0]     BranchTarget,
    input  logic              Halt,
    output logic [IW-1:0]     InstAddress,
    input  logic [INST_W-1:0] InstIn,
    output logic [INST_W-1:0] InstOut,
    output logic              InstValid,
    output logic [IW-1:0]     PCOut,
    output logic              Done
);

    fetch_state_t        state, state_nx;
    logic [IW-1:0]       pc, pc_nx;
    logic [IW-1:0]       pc_out_nx;
    logic [INST_W-1:0]   inst_nx;
    logic                valid_nx;
    logic                done_nx;
    // Set on Start: the first RUN cycle only primes the pipeline, so the first
    // live instruction is registered at the second edge after Start is taken.
    logic                fill, fill_nx;
    pc_sel_t             pc_sel;
    logic [IW-1:0]       pc_calc;

    assign InstAddress = pc;

    pc_next #(
        .IW(IW)
    ) u_pc_next (
        .sel     (pc_sel),
        .pc      (pc),
        .pc_out  (PCOut),
        .target  (BranchTarget),
        .next_pc (pc_calc)
    );

    // Next-state and register-update decisions; everything holds by default.
    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        pc_out_nx = PCOut;
        inst_nx   = InstOut;
        valid_nx  = InstValid;
        done_nx   = Done;
        fill_nx   = fill;
        pc_sel    = PC_INC;

        unique case (state)
            IDLE, HALTED: begin
                if (Start) begin
                    pc_nx    = StartAddr;
                    valid_nx = 1'b0;
                    done_nx  = 1'b0;
                    fill_nx  = 1'b1;
                    state_nx = RUN;
                end
            end

            RUN: begin
                // A stall freezes everything, including any pending halt or branch.
                if (!Stall) begin
                    if (fill) begin
                        fill_nx = 1'b0;
                    end else if (InstValid && Halt) begin
                        state_nx = HALTED;
                        valid_nx = 1'b0;
                        done_nx  = 1'b1;
                    end else if (InstValid && BranchEn) begin
                        // The sequentially fetched word is discarded; the
                        // target is fetched on the following cycle.
                        pc_sel   = BranchRel ? PC_REL : PC_ABS;
                        pc_nx    = pc_calc;
                        valid_nx = 1'b0;
                    end else begin
                        pc_sel    = PC_INC;
                        inst_nx   = InstIn;
                        pc_out_nx = pc;
                        valid_nx  = 1'b1;
                        pc_nx     = pc_calc;
                    end
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-high reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            pc        <= '0;
            PCOut     <= '0;
            InstOut   <= '0;
            InstValid <= 1'b0;
            Done      <= 1'b0;
            fill      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_nx;
            pc        <= pc_nx;
            PCOut     <= pc_out_nx;
            InstOut   <= inst_nx;
            InstValid <= valid_nx;
            Done      <= done_nx;
            fill      <= fill_nx;
        end
    end

endmodule
